// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from the EX/MEM and MEM/WB
// producers, stall/flush control and a saturating stall-cycle counter.
module id_ex_stage #(
   parameter int CNT_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [31:0]       id_ins,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic [4:0]        id_dest,
   input  logic              id_regwrite,
   input  logic [4:0]        mem_dest,
   input  logic              mem_regwrite,
   input  logic [DATA_W-1:0] mem_result,
   input  logic [4:0]        wb_dest,
   input  logic              wb_regwrite,
   input  logic [DATA_W-1:0] wb_result,
   output logic [DATA_W-1:0] op1,
   output logic [DATA_W-1:0] op2,
   output logic [31:0]       ins,
   output logic [4:0]        ex_dest,
   output logic              ex_regwrite,
   output logic              ex_valid,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [31:0]       ins_q;
   logic [DATA_W-1:0] rs_q;
   logic [DATA_W-1:0] rt_q;
   logic [4:0]        dest_q;
   logic              regwrite_q;
   logic              valid_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [4:0]        rs;
   logic [4:0]        rt;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + 1'b1;
   endfunction

   // Operand select: the younger MEM producer beats WB; register 0 never forwards.
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [4:0]        src,
      input logic [DATA_W-1:0] held
   );
      if (src != 5'd0 && mem_regwrite && mem_dest == src) return mem_result;
      if (src != 5'd0 && wb_regwrite && wb_dest == src)   return wb_result;
      return held;
   endfunction

   assign rs = ins_q[25:21];
   assign rt = ins_q[20:16];

   // Forwarding muxes in front of the ALU.
   always_comb begin
      op1 = fwd_sel(rs, rs_q);
      op2 = fwd_sel(rt, rt_q);
   end

   assign ins         = ins_q;
   assign ex_dest     = dest_q;
   assign ex_regwrite = regwrite_q;
   assign ex_valid    = valid_q;
   assign stall_cnt   = cnt_q;

   // EX register: flush beats stall; a stall re-captures the forwarded operands
   // so a producer retiring out of WB during the stall is not lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ins_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         dest_q     <= '0;
         regwrite_q <= 1'b0;
         valid_q    <= 1'b0;
      end else if (flush) begin
         ins_q      <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         dest_q     <= '0;
         regwrite_q <= 1'b0;
         valid_q    <= 1'b0;
      end else if (stall) begin
         rs_q <= op1;
         rt_q <= op2;
      end else begin
         ins_q      <= id_valid ? id_ins : 32'd0;
         rs_q       <= id_rs_val;
         rt_q       <= id_rt_val;
         dest_q     <= id_dest;
         regwrite_q <= id_regwrite & id_valid;
         valid_q    <= id_valid;
      end
   end

   // Count stalled cycles; a flushed cycle is not a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (stall && !flush)
         cnt_q <= sat_inc(cnt_q);
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding priority, stall/flush, counter
// saturation and asynchronous reset.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush;
   logic        id_valid;
   logic [31:0] id_ins, id_rs_val, id_rt_val;
   logic [4:0]  id_dest;
   logic        id_regwrite;
   logic [4:0]  mem_dest;
   logic        mem_regwrite;
   logic [31:0] mem_result;
   logic [4:0]  wb_dest;
   logic        wb_regwrite;
   logic [31:0] wb_result;
   logic [31:0] op1, op2, ins;
   logic [4:0]  ex_dest;
   logic        ex_regwrite, ex_valid;
   logic [15:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   id_ex_stage #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_ins(id_ins), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
      .id_dest(id_dest), .id_regwrite(id_regwrite),
      .mem_dest(mem_dest), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
      .wb_dest(wb_dest), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
      .op1(op1), .op2(op2), .ins(ins), .ex_dest(ex_dest),
      .ex_regwrite(ex_regwrite), .ex_valid(ex_valid), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic v, input logic [31:0] w, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d);
      id_valid = v; id_ins = w; id_rs_val = a; id_rt_val = b; id_dest = d; id_regwrite = 1'b1;
   endtask

   task automatic no_fwd();
      mem_dest = 5'd0; mem_regwrite = 1'b0; mem_result = 32'd0;
      wb_dest = 5'd0; wb_regwrite = 1'b0; wb_result = 32'd0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      load(1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
      no_fwd();
      #1;
      check_eq("rst_ins", ins, 32'd0);
      check_eq("rst_op1", op1, 32'd0);
      check_eq("rst_op2", op2, 32'd0);
      check_eq("rst_valid", 32'(ex_valid), 32'd0);
      check_eq("rst_cnt", 32'(stall_cnt), 32'd0);
      step();
      rst = 1'b0;

      // add r3,r1,r2 with no forwarding
      load(1'b1, 32'h0022_1820, 32'd5, 32'd7, 5'd3);
      step();
      check_eq("add_ins", ins, 32'h0022_1820);
      check_eq("add_op1", op1, 32'd5);
      check_eq("add_op2", op2, 32'd7);
      check_eq("add_dest", 32'(ex_dest), 32'd3);
      check_eq("add_valid", 32'(ex_valid), 32'd1);
      check_eq("add_regwr", 32'(ex_regwrite), 32'd1);

      // MEM beats WB on rs=1, then WB alone, then neither
      mem_dest = 5'd1; mem_regwrite = 1'b1; mem_result = 32'h10;
      wb_dest = 5'd1; wb_regwrite = 1'b1; wb_result = 32'h20;
      #1;
      check_eq("fwd_mem_op1", op1, 32'h10);
      check_eq("fwd_mem_op2", op2, 32'd7);
      mem_regwrite = 1'b0;
      #1;
      check_eq("fwd_wb_op1", op1, 32'h20);
      wb_regwrite = 1'b0;
      #1;
      check_eq("fwd_none_op1", op1, 32'd5);

      // add r4,r0,r2: register 0 is never forwarded
      load(1'b1, 32'h0002_2020, 32'd0, 32'd9, 5'd4);
      step();
      mem_dest = 5'd0; mem_regwrite = 1'b1; mem_result = 32'hFF;
      wb_dest = 5'd0; wb_regwrite = 1'b1; wb_result = 32'hEE;
      #1;
      check_eq("r0_op1", op1, 32'd0);
      check_eq("r0_op2", op2, 32'd9);
      no_fwd();

      // invalid ID slot becomes a bubble
      load(1'b0, 32'h0022_1820, 32'd5, 32'd7, 5'd3);
      step();
      check_eq("inv_ins", ins, 32'd0);
      check_eq("inv_valid", 32'(ex_valid), 32'd0);
      check_eq("inv_regwr", 32'(ex_regwrite), 32'd0);

      // stall 3 cycles, WB forwards rt=2 only during the first
      load(1'b1, 32'h0022_1820, 32'd5, 32'd7, 5'd3);
      step();
      stall = 1'b1;
      wb_dest = 5'd2; wb_regwrite = 1'b1; wb_result = 32'h99;
      load(1'b1, 32'h1234_5678, 32'd1, 32'd2, 5'd9);
      #1;
      check_eq("stl0_op2", op2, 32'h99);
      step();
      no_fwd();
      #1;
      check_eq("stl1_op2", op2, 32'h99);
      check_eq("stl1_ins", ins, 32'h0022_1820);
      step();
      check_eq("stl2_op2", op2, 32'h99);
      step();
      check_eq("stl3_op2", op2, 32'h99);
      check_eq("stl3_op1", op1, 32'd5);
      check_eq("stl3_ins", ins, 32'h0022_1820);
      check_eq("stl3_dest", 32'(ex_dest), 32'd3);
      check_eq("stl3_cnt", 32'(stall_cnt), 32'd3);

      // flush wins over stall and is not counted
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_eq("fl_ins", ins, 32'd0);
      check_eq("fl_valid", 32'(ex_valid), 32'd0);
      check_eq("fl_regwr", 32'(ex_regwrite), 32'd0);
      check_eq("fl_op2", op2, 32'd0);
      check_eq("fl_cnt", 32'(stall_cnt), 32'd3);

      // drive the counter to all-ones, then one more stall must not wrap
      repeat (65532) step();
      check_eq("sat_reach", 32'(stall_cnt), 32'h0000_FFFF);
      step();
      check_eq("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
      stall = 1'b0;

      // asynchronous reset between edges on a valid instruction
      load(1'b1, 32'h0022_1820, 32'd5, 32'd7, 5'd3);
      step();
      check_eq("pre_rst_valid", 32'(ex_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_ins", ins, 32'd0);
      check_eq("arst_op1", op1, 32'd0);
      check_eq("arst_op2", op2, 32'd0);
      check_eq("arst_valid", 32'(ex_valid), 32'd0);
      check_eq("arst_dest", 32'(ex_dest), 32'd0);
      check_eq("arst_cnt", 32'(stall_cnt), 32'd0);
      stall = 1'b1;
      step();
      check_eq("rst_hold_ins", ins, 32'd0);
      check_eq("rst_hold_cnt", 32'(stall_cnt), 32'd0);
      stall = 1'b0;
      rst = 1'b0;
      step();
      check_eq("post_rst_ins", ins, 32'h0022_1820);
      check_eq("post_rst_op1", op1, 32'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: stall  in  1  hold EX contents this cycle; flush  in  1  replace EX contents with bubble.
REQ-004 SHALL have ports: id_valid  in  1;  id_ins  in  32  decoded R-type word;  id_rs_val, id_rt_val  in  32  register-file reads.
REQ-005 SHALL have ports: id_dest  in  5;  id_regwrite  in  1.
REQ-006 SHALL have ports: mem_dest  in  5;  mem_regwrite  in  1;  mem_result  in  32  (EX/MEM producer).
REQ-007 SHALL have ports: wb_dest  in  5;  wb_regwrite  in  1;  wb_result  in  32  (MEM/WB producer).
REQ-008 SHALL have ports: op1, op2  out  32  ALU operands;  ins  out  32  ALU instruction word.
REQ-009 SHALL have ports: ex_dest  out  5;  ex_regwrite  out  1;  ex_valid  out  1;  stall_cnt  out  16.
REQ-010 SHALL have parameter: CNT_W, default 16, width of stall_cnt.

Function
REQ-011 SHALL hold registers ins_q, rs_q, rt_q, dest_q, regwrite_q, valid_q, all updated on rising clk only.
REQ-012 SHALL, when flush=1, load ins_q=0, dest_q=0, regwrite_q=0, valid_q=0 on the next edge; rs_q/rt_q SHALL load 0.
REQ-013 SHALL give flush priority over stall when both are 1.
REQ-014 SHALL, when stall=1 and flush=0, keep ins_q, dest_q, regwrite_q, valid_q, and load rs_q<=op1, rt_q<=op2 (capture forwarded values so a producer leaving WB is not lost).
REQ-015 SHALL, when stall=0 and flush=0, load ins_q<=id_ins, rs_q<=id_rs_val, rt_q<=id_rt_val, dest_q<=id_dest, valid_q<=id_valid, regwrite_q<=id_regwrite&id_valid; when id_valid=0 ins_q SHALL load 0.
REQ-016 SHALL derive rs=ins_q[25:21], rt=ins_q[20:16].
REQ-017 SHALL compute op1 combinationally: mem_result if mem_regwrite and mem_dest==rs and rs!=0; else wb_result if wb_regwrite and wb_dest==rs and rs!=0; else rs_q.
REQ-018 SHALL compute op2 identically using rt and rt_q.
REQ-019 SHALL give MEM forwarding priority over WB when both match.
REQ-020 SHALL never forward to register 0; op1/op2 for source 0 SHALL equal rs_q/rt_q.
REQ-021 SHALL drive ins=ins_q, ex_dest=dest_q, ex_regwrite=regwrite_q, ex_valid=valid_q directly; latency ID->EX = 1 cycle.
REQ-022 SHALL increment stall_cnt on each edge with stall=1 and flush=0, saturating at all-ones (no wrap).
REQ-023 SHALL not forward or count on bubble state beyond REQ-017..022 rules; a bubble (ins=0) SHALL present as ALU nop.

Reset
REQ-024 SHALL, on rst=1, immediately (without clk) set ins_q, rs_q, rt_q, dest_q, regwrite_q, valid_q and stall_cnt to 0.
REQ-025 SHALL keep all registers at 0 while rst=1 regardless of stall/flush/id inputs; first capture on first rising clk after rst falls.
REQ-026 SHALL, on rst asserted mid-stall, discard held instruction; op1/op2 then reflect only forwarding inputs or 0.

Verification
REQ-027 SHALL cover: id_ins=add r3,r1,r2 (0x00221820), id_rs_val=5, id_rt_val=7, no forwarding -> next cycle ins=0x00221820, op1=5, op2=7, ex_dest=3, ex_valid=1.
REQ-028 SHALL cover: same ins, mem_dest=1 mem_regwrite=1 mem_result=0x10, wb_dest=1 wb_regwrite=1 wb_result=0x20 -> op1=0x10 (MEM wins); drop mem_regwrite -> op1=0x20.
REQ-029 SHALL cover: ins with rs=0, mem_dest=0 mem_regwrite=1 mem_result=0xFF, rs_q=0 -> op1=0.
REQ-030 SHALL cover: stall=1 for 3 cycles with wb forwarding rt=2 value 0x99 on first stall cycle only -> op2 stays 0x99 all 3 cycles, ins unchanged, stall_cnt=3.
REQ-031 SHALL cover: stall=1 and flush=1 same edge -> ins=0, ex_valid=0, ex_regwrite=0, stall_cnt unchanged; stall_cnt preset to 0xFFFF plus stall -> stays 0xFFFF.
REQ-032 SHALL cover: rst pulse between clk edges during valid instruction -> all outputs 0 before next edge (op1/op2=0 with no forwarding).
